// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone B4 arbiter with round-robin grant held for the
// whole bus cycle and a watchdog that terminates strobes the slave never answers.
module wb_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // master 0 (instruction fetch)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [2:0]  m0_cti_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  output logic [31:0] m0_dat_o,
  // master 1 (load/store unit)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [2:0]  m1_cti_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic [31:0] m1_dat_o,
  // slave side
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic [2:0]  CTI_O,
  input  logic        ACK_I,
  input  logic        ERR_I,
  input  logic        RTY_I,
  input  logic [31:0] DAT_I,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam bit WD_EN = (TIMEOUT > 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GNT_M0 = 2'd1;
  localparam logic [1:0] GNT_M1 = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic          last_r;
  logic          last_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;

  logic          sel_m0_s;
  logic          sel_m1_s;
  logic          gcyc_s;
  logic          gstb_s;
  logic          term_s;
  logic          fire_s;
  logic          drive_s;

  logic          mux_we_s;
  logic [31:0]   mux_adr_s;
  logic [31:0]   mux_dat_s;
  logic [3:0]    mux_sel_s;
  logic [2:0]    mux_cti_s;

  // Decode the granted master's cycle/strobe and the watchdog fire condition.
  always_comb begin
    sel_m0_s = (state_r == GNT_M0);
    sel_m1_s = (state_r == GNT_M1);
    gcyc_s   = (sel_m0_s & m0_cyc_i) | (sel_m1_s & m1_cyc_i);
    gstb_s   = (sel_m0_s & m0_stb_i) | (sel_m1_s & m1_stb_i);
    term_s   = ACK_I | ERR_I | RTY_I;
    // Counter holds the number of already-elapsed unanswered cycles, so the
    // TIMEOUT-th one is the cycle where it reads TIMEOUT-1.
    fire_s   = WD_EN & gcyc_s & gstb_s & ~term_s & (cnt_r == CNT_LAST);
    drive_s  = gcyc_s & ~fire_s;
  end

  // Select the granted master's request fields.
  always_comb begin
    case (state_r)
      GNT_M0: begin
        mux_we_s  = m0_we_i;
        mux_adr_s = m0_adr_i;
        mux_dat_s = m0_dat_i;
        mux_sel_s = m0_sel_i;
        mux_cti_s = m0_cti_i;
      end
      GNT_M1: begin
        mux_we_s  = m1_we_i;
        mux_adr_s = m1_adr_i;
        mux_dat_s = m1_dat_i;
        mux_sel_s = m1_sel_i;
        mux_cti_s = m1_cti_i;
      end
      default: begin
        mux_we_s  = 1'b0;
        mux_adr_s = 32'h0000_0000;
        mux_dat_s = 32'h0000_0000;
        mux_sel_s = 4'h0;
        mux_cti_s = 3'b000;
      end
    endcase
  end

  // Slave-side outputs, zeroed whenever no live granted cycle is being driven.
  always_comb begin
    if (drive_s) begin
      CYC_O = 1'b1;
      STB_O = gstb_s;
      WE_O  = mux_we_s;
      ADR_O = mux_adr_s;
      DAT_O = mux_dat_s;
      SEL_O = mux_sel_s;
      CTI_O = mux_cti_s;
    end else begin
      CYC_O = 1'b0;
      STB_O = 1'b0;
      WE_O  = 1'b0;
      ADR_O = 32'h0000_0000;
      DAT_O = 32'h0000_0000;
      SEL_O = 4'h0;
      CTI_O = 3'b000;
    end
  end

  // Terminations routed only to the granted master; read data broadcast.
  always_comb begin
    m0_ack_o  = sel_m0_s & ACK_I;
    m0_err_o  = sel_m0_s & (ERR_I | fire_s);
    m0_rty_o  = sel_m0_s & RTY_I;
    m1_ack_o  = sel_m1_s & ACK_I;
    m1_err_o  = sel_m1_s & (ERR_I | fire_s);
    m1_rty_o  = sel_m1_s & RTY_I;
    m0_dat_o  = DAT_I;
    m1_dat_o  = DAT_I;
    grant_o   = {sel_m1_s, sel_m0_s};
    timeout_o = fire_s;
  end

  // Round-robin arbitration; grant is locked until the owner drops cyc.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt_s = last_r ? GNT_M0 : GNT_M1;
        end else if (m0_cyc_i) begin
          state_nxt_s = GNT_M0;
        end else if (m1_cyc_i) begin
          state_nxt_s = GNT_M1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_M0: begin
        if (m0_cyc_i) begin
          state_nxt_s = GNT_M0;
        end else begin
          last_nxt_s  = 1'b0;
          state_nxt_s = m1_cyc_i ? GNT_M1 : IDLE;
        end
      end
      GNT_M1: begin
        if (m1_cyc_i) begin
          state_nxt_s = GNT_M1;
        end else begin
          last_nxt_s  = 1'b1;
          state_nxt_s = m0_cyc_i ? GNT_M0 : IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        last_nxt_s  = 1'b1;
      end
    endcase
  end

  // Watchdog counts consecutive unanswered strobe cycles of the granted master.
  always_comb begin
    if ((state_r == IDLE) || term_s || !gcyc_s || !gstb_s || fire_s) begin
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // State, last-served and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed-vector bench for wb_bus_arbiter (TIMEOUT=3): the driver queues the
// hand-computed expected response of each cycle, a negedge monitor compares.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_adr_i = 32'h0, m0_dat_i = 32'h0;
  logic [3:0]  m0_sel_i = 4'hF;
  logic [2:0]  m0_cti_i = 3'b000;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b1;
  logic [31:0] m1_adr_i = 32'h0, m1_dat_i = 32'h0000_00D1;
  logic [3:0]  m1_sel_i = 4'h3;
  logic [2:0]  m1_cti_i = 3'b000;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] m1_dat_o;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic [2:0]  CTI_O;
  logic        ACK_I = 1'b0, ERR_I = 1'b0, RTY_I = 1'b0;
  logic [31:0] DAT_I = 32'hCAFE_F00D;
  logic [1:0]  grant_o;
  logic        timeout_o;

  wb_bus_arbiter #(.TIMEOUT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .SEL_O(SEL_O), .CTI_O(CTI_O), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I),
    .DAT_I(DAT_I), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  g;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [1:0]  rty;
    logic        tmo;
    logic [31:0] d0;
    logic [31:0] d1;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic [31:0] a0 = 32'h1000_0040;
  logic [31:0] a1 = 32'h2000_0000;

  // Apply one cycle of stimulus and queue the hand-computed response.
  // trm = {ACK_I, ERR_I, RTY_I}; two-bit expectations are {m1, m0}.
  task automatic v(input string nm, input logic rn,
                   input logic c0, input logic [2:0] t0,
                   input logic c1, input logic [2:0] t1,
                   input logic [2:0] trm, input logic [1:0] eg, input logic ec,
                   input logic [1:0] eack, input logic [1:0] eerr,
                   input logic [1:0] erty, input logic etmo);
    obs_t e;
    @(posedge clk);
    #1;
    rst_n    = rn;
    m0_cyc_i = c0;  m0_stb_i = c0;  m0_cti_i = t0;  m0_adr_i = a0;
    m1_cyc_i = c1;  m1_stb_i = c1;  m1_cti_i = t1;  m1_adr_i = a1;
    ACK_I    = trm[2];
    ERR_I    = trm[1];
    RTY_I    = trm[0];
    e.g   = eg;
    e.cyc = ec;
    e.stb = ec;
    e.we  = ec & eg[1];
    e.adr = ec ? (eg[0] ? a0 : a1) : 32'h0;
    e.cti = ec ? (eg[0] ? t0 : t1) : 3'b000;
    e.ack = eack;
    e.err = eerr;
    e.rty = erty;
    e.tmo = etmo;
    e.d0  = DAT_I;
    e.d1  = DAT_I;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation mid-cycle.
  always @(negedge clk) begin
    obs_t  a;
    obs_t  e;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {grant_o, CYC_O, STB_O, WE_O, ADR_O, CTI_O,
           {m1_ack_o, m0_ack_o}, {m1_err_o, m0_err_o}, {m1_rty_o, m0_rty_o},
           timeout_o, m0_dat_o, m1_dat_o};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", n, a, e);
      end
    end
  end

  initial begin
    //  name         rn c0 t0      c1 t1      trm     eg     ec eack   eerr   erty   tmo
    v("rst_ack",     0, 1, 3'b000, 0, 3'b000, 3'b100, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    v("rst",         0, 0, 3'b000, 0, 3'b000, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    v("idle",        1, 0, 3'b000, 0, 3'b000, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    v("m0_req",      1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    v("m0_gnt",      1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0);
    v("m0_ack",      1, 1, 3'b000, 0, 3'b000, 3'b100, 2'b01, 1, 2'b01, 2'b00, 2'b00, 0);
    v("m0_drop",     1, 0, 3'b000, 0, 3'b000, 3'b000, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0);
    v("idle2",       1, 0, 3'b000, 0, 3'b000, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    // m0 was served last, so this tie goes to m1
    v("tie_a",       1, 1, 3'b000, 1, 3'b000, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    v("tie_a_g1",    1, 1, 3'b000, 1, 3'b000, 3'b000, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0);
    v("g1_ack",      1, 1, 3'b000, 1, 3'b000, 3'b100, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0);
    v("m1_drop",     1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0);
    v("handover",    1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0);
    v("m0_rty",      1, 1, 3'b000, 0, 3'b000, 3'b001, 2'b01, 1, 2'b00, 2'b00, 2'b01, 0);
    v("m0_drop2",    1, 0, 3'b000, 0, 3'b000, 3'b000, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0);
    v("idle3",       1, 0, 3'b000, 0, 3'b000, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    // m1 incrementing burst while m0 keeps requesting
    v("bst_req",     1, 1, 3'b000, 1, 3'b010, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    v("bst0",        1, 1, 3'b000, 1, 3'b010, 3'b100, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0);
    a1 = 32'h2000_0004;
    v("bst1",        1, 1, 3'b000, 1, 3'b010, 3'b100, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0);
    a1 = 32'h2000_0008;
    v("bst2",        1, 1, 3'b000, 1, 3'b010, 3'b100, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0);
    a1 = 32'h2000_000C;
    v("bst3",        1, 1, 3'b000, 1, 3'b111, 3'b100, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0);
    v("bst_end",     1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0);
    // watchdog: slave silent, fires on the 3rd strobe cycle
    v("wd1",         1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0);
    v("wd2",         1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0);
    v("wd3_fire",    1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b01, 0, 2'b00, 2'b01, 2'b00, 1);
    v("wd_re1",      1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0);
    v("wd_re2",      1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0);
    v("wd_ack_tie",  1, 1, 3'b000, 0, 3'b000, 3'b100, 2'b01, 1, 2'b01, 2'b00, 2'b00, 0);
    v("ack_clr1",    1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0);
    v("ack_clr2",    1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0);
    v("wd_again",    1, 1, 3'b000, 0, 3'b000, 3'b000, 2'b01, 0, 2'b00, 2'b01, 2'b00, 1);
    v("m0_drop3",    1, 0, 3'b000, 0, 3'b000, 3'b000, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0);
    v("idle4",       1, 0, 3'b000, 0, 3'b000, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    // reset asserted mid-burst, then a tie must go to m0
    v("r_req",       1, 0, 3'b000, 1, 3'b010, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    v("r_bst0",      1, 0, 3'b000, 1, 3'b010, 3'b100, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0);
    v("r_async",     0, 0, 3'b000, 1, 3'b010, 3'b100, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    v("r_hold",      0, 1, 3'b000, 1, 3'b000, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    v("r_tie",       1, 1, 3'b000, 1, 3'b000, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    v("r_tie_g0",    1, 1, 3'b000, 1, 3'b000, 3'b000, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0);
    v("r_err",       1, 1, 3'b000, 1, 3'b000, 3'b010, 2'b01, 1, 2'b00, 2'b01, 2'b00, 0);
    v("r_drop0",     1, 0, 3'b000, 1, 3'b000, 3'b000, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0);
    v("r_g1",        1, 0, 3'b000, 1, 3'b000, 3'b000, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0);
    v("r_drop1",     1, 0, 3'b000, 0, 3'b000, 3'b000, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0);
    v("idle5",       1, 0, 3'b000, 0, 3'b000, 3'b000, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
